// File: rtl/approx_err_sweep_ctrl.sv
// approx_err_sweep_ctrl: sweeps all (a,b) pairs up to end_cnt through an approximate adder and accumulates error statistics
//   clk, rst            clock, asynchronous active-high reset
//   start, end_cnt      sweep request (IDLE only) and inclusive last index
//   hold, abort         pause issue / terminate sweep
//   busy, done, aborted status (busy in RUN/DRAIN, done pulse, sticky abort flag)
//   err_count, max_abs_err, sum_abs_err, sum_sq_err   error statistics
module approx_err_sweep_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] end_cnt,
    input  logic        hold,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [16:0] err_count,
    output logic [8:0]  max_abs_err,
    output logic [31:0] sum_abs_err,
    output logic [31:0] sum_sq_err
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    logic [1:0]  state;
    logic [15:0] idx, end_q;
    logic        dcnt, v1;
    logic [7:0]  a, b, s;
    logic [8:4]  c;
    logic [8:0]  approx, exact, ap1, ex1, abs_err;
    logic [9:0]  err;
    logic [17:0] sq;
    logic        accept, issue, last, abort_hit;
    assign a = idx[15:8];
    assign b = idx[7:0];
    // LSB cells pass a through as sum and b as carry, so only b[3] reaches the exact MSB half
    assign s[3:0] = a[3:0];
    assign c[4]   = b[3];
    for (genvar i = 4; i < 8; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign approx = {c[8], s};
    assign exact  = {1'b0, a} + {1'b0, b};
    assign busy      = state == RUN || state == DRAIN;
    assign done      = state == DONE;
    assign accept    = state == IDLE && start;
    assign abort_hit = busy && abort;
    assign issue     = state == RUN && !hold && !abort;
    assign last      = idx == end_q;
    assign err     = {1'b0, ap1} - {1'b0, ex1};
    assign abs_err = err[9] ? 9'(-err) : err[8:0];
    assign sq      = abs_err * abs_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            end_q       <= '0;
            dcnt        <= 1'b0;
            v1          <= 1'b0;
            ap1         <= '0;
            ex1         <= '0;
            aborted     <= 1'b0;
            err_count   <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
            sum_sq_err  <= '0;
        end else begin
            state   <= abort_hit ? IDLE :
                       accept ? RUN :
                       (issue && last) ? DRAIN :
                       (state == DRAIN && dcnt) ? DONE :
                       state == DONE ? IDLE : state;
            dcnt    <= state == DRAIN && !dcnt;
            idx     <= accept ? '0 : (issue && !last) ? idx + 16'd1 : idx;
            end_q   <= accept ? end_cnt : end_q;
            aborted <= accept ? 1'b0 : abort_hit ? 1'b1 : aborted;
            v1      <= issue;
            ap1     <= approx;
            ex1     <= exact;
            // an abort discards the entry sitting in stage 1 as well
            if (accept) begin
                err_count   <= '0;
                max_abs_err <= '0;
                sum_abs_err <= '0;
                sum_sq_err  <= '0;
            end else if (v1 && !abort_hit) begin
                err_count   <= err_count + 17'(err != 10'd0);
                max_abs_err <= abs_err > max_abs_err ? abs_err : max_abs_err;
                sum_abs_err <= sum_abs_err + 32'(abs_err);
                sum_sq_err  <= sum_sq_err + 32'(sq);
            end
        end
    end
endmodule

// File: tb/tb_approx_err_sweep_ctrl.sv
// tb_approx_err_sweep_ctrl: table-driven and directed checks of approx_err_sweep_ctrl against a behavioural error model
module tb_approx_err_sweep_ctrl;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, hold = 1'b0, abort = 1'b0;
    logic [15:0] end_cnt = '0;
    logic        busy, done, aborted;
    logic [16:0] err_count;
    logic [8:0]  max_abs_err;
    logic [31:0] sum_abs_err, sum_sq_err;
    int n_run = 0, n_fail = 0;
    typedef struct {
        logic [15:0] e;
        int hat, hlen, poke, lat;
    } vec_t;
    typedef struct {
        int hat, hlen, poke, lat, ec, mx;
        longint sa, sq;
    } res_t;
    vec_t vecs[6];
    res_t sb[$];
    approx_err_sweep_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .end_cnt(end_cnt), .hold(hold), .abort(abort),
        .busy(busy), .done(done), .aborted(aborted), .err_count(err_count),
        .max_abs_err(max_abs_err), .sum_abs_err(sum_abs_err), .sum_sq_err(sum_sq_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input longint act, input longint exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    // error of the approximate adder taken straight from its arithmetic definition
    function automatic res_t model(input vec_t v);
        res_t r;
        r = '{v.hat, v.hlen, v.poke, v.lat, 0, 0, 0, 0};
        for (int i = 0; i <= int'(v.e); i++) begin
            int a, b, ap, er, ab;
            a  = i / 256;
            b  = i % 256;
            ap = (a / 16 + b / 16 + (b / 8) % 2) * 16 + a % 16;
            er = ap - (a + b);
            ab = er < 0 ? -er : er;
            if (er != 0) r.ec++;
            if (ab > r.mx) r.mx = ab;
            r.sa += ab;
            r.sq += ab * ab;
        end
        return r;
    endfunction
    task automatic go(input vec_t v);
        sb.push_back(model(v));
        @(negedge clk);
        start   = 1'b1;
        end_cnt = v.e;
        @(posedge clk);
        #1 start = 1'b0;
        chk("aborted cleared on start", aborted, 0);
    endtask
    task automatic wait_done(input string nm);
        res_t r;
        int c;
        r = sb[0];
        c = 0;
        do begin
            @(negedge clk);
            c++;
            hold = r.hlen != 0 && c >= r.hat && c < r.hat + r.hlen;
            if (c == r.poke) begin
                start   = 1'b1;
                end_cnt = 16'h0000;
            end else start = 1'b0;
            if (c == 1) chk({nm, " busy"}, busy, 1);
        end while (!done && c < r.lat + 20);
        hold  = 1'b0;
        start = 1'b0;
        void'(sb.pop_front());
        chk({nm, " latency"}, c, r.lat);
        chk({nm, " busy in done"}, busy, 0);
        chk({nm, " err_count"}, err_count, r.ec);
        chk({nm, " max_abs_err"}, max_abs_err, r.mx);
        chk({nm, " sum_abs_err"}, sum_abs_err, r.sa);
        chk({nm, " sum_sq_err"}, sum_sq_err, r.sq);
        start   = 1'b1;
        end_cnt = 16'h0005;
        @(posedge clk);
        #1 start = 1'b0;
        chk({nm, " start in done ignored"}, busy, 0);
        @(negedge clk);
        chk({nm, " done one cycle"}, done, 0);
        chk({nm, " results stable"}, sum_sq_err, r.sq);
    endtask
    initial begin
        vecs[0] = '{16'h0000, 0, 0, 0, 4};
        vecs[1] = '{16'h0008, 0, 0, 0, 12};
        vecs[2] = '{16'h0008, 3, 5, 0, 17};
        vecs[3] = '{16'h0017, 0, 0, 0, 27};
        vecs[4] = '{16'h0123, 10, 3, 0, 298};
        vecs[5] = '{16'h0020, 0, 0, 5, 36};
        #12;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset aborted", aborted, 0);
        chk("reset err_count", err_count, 0);
        chk("reset max", max_abs_err, 0);
        chk("reset sums", sum_abs_err + sum_sq_err, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            go(vecs[i]);
            wait_done($sformatf("vec%0d", i));
        end
        @(negedge clk);
        start   = 1'b1;
        end_cnt = 16'h0100;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        #1 rst = 1'b1;
        #2;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst aborted", aborted, 0);
        chk("rst err_count", err_count, 0);
        chk("rst max", max_abs_err, 0);
        chk("rst sum_abs", sum_abs_err, 0);
        chk("rst sum_sq", sum_sq_err, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst no restart", busy, 0);
        chk("rst accum idle", err_count, 0);
        @(negedge clk);
        start   = 1'b1;
        end_cnt = 16'hFFFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (50) @(negedge clk);
        chk("abort busy before", busy, 1);
        abort = 1'b1;
        hold  = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        hold  = 1'b0;
        chk("abort idle", busy, 0);
        chk("abort flag", aborted, 1);
        chk("abort partial", err_count != 0, 1);
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (done) seen = 1;
            end
            chk("abort no done", seen, 0);
        end
        chk("abort sticky", aborted, 1);
        go('{16'hFFFF, 0, 0, 0, 65539});
        wait_done("full");
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
